// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a line-refill FSM over a req/gnt + rvalid memory port.
// Hits return data combinationally; misses stall the core until the line is written.
module icache_refill #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 10,
  parameter int LINES  = 8,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inv,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [INST_W-1:0] core_data,
  output logic              core_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [15:0]       miss_cnt
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REFILL, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [INST_W-1:0]   r_data [LINES][WORDS];
  logic [ADDR_W-1:0]   r_miss_addr;
  logic [OFF_W-1:0]    r_beat;
  logic                r_drop;
  logic [15:0]         r_miss_cnt;

  logic [OFF_W-1:0]    w_off;
  logic [IDX_W-1:0]    w_idx, w_miss_idx;
  logic [TAG_W-1:0]    w_tag, w_miss_tag;
  logic                w_hit, w_start, w_last;

  assign w_off      = core_addr[OFF_W-1:0];
  assign w_idx      = core_addr[OFF_W +: IDX_W];
  assign w_tag      = core_addr[ADDR_W-1 -: TAG_W];
  assign w_miss_idx = r_miss_addr[OFF_W +: IDX_W];
  assign w_miss_tag = r_miss_addr[ADDR_W-1 -: TAG_W];

  // An invalidate pulse suppresses the lookup in the same cycle it clears the valids.
  assign w_hit   = (r_state == S_IDLE) & ~inv & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_start = (r_state == S_IDLE) & en & ~w_hit & ~inv;
  assign w_last  = mem_rvalid & (r_beat == OFF_W'(WORDS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_REQ;
      S_REQ:    if (mem_gnt) w_next = S_REFILL;
      S_REFILL: if (w_last)  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (r_state == S_REQ);
    mem_addr   = r_miss_addr;
    core_stall = ~w_hit;
    core_data  = w_hit ? r_data[w_idx][w_off] : '0;
    miss_cnt   = r_miss_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_miss_addr <= '0;
      r_beat      <= '0;
      r_drop      <= 1'b0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_miss_addr <= {core_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      end
      if (r_state == S_REQ && mem_gnt)           r_beat <= '0;
      else if (r_state == S_REFILL && mem_rvalid) r_beat <= r_beat + 1'b1;
      if (inv)                             r_valid <= '0;
      else if (r_state == S_DONE && !r_drop) r_valid[w_miss_idx] <= 1'b1;
      // A dropped refill still finishes its handshake; the flag only lives until DONE.
      if (r_state == S_DONE)                r_drop <= 1'b0;
      else if (inv && r_state != S_IDLE)    r_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_rvalid) r_data[w_miss_idx][r_beat] <= mem_rdata;
    if (r_state == S_DONE)                 r_tag[w_miss_idx] <= w_miss_tag;
  end

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: the bench plays the memory arbiter and keeps a
// line-level model of which lines are resident, plus a fixed address->word memory image.
module tb_icache_refill;
  localparam int INST_W = 32;
  localparam int ADDR_W = 10;
  localparam int LINES  = 8;
  localparam int WORDS  = 4;
  localparam int OFF_W  = 2;
  localparam int IDX_W  = 3;

  logic              clk = 1'b0;
  logic              rst, en, inv, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] core_addr, mem_addr;
  logic [INST_W-1:0] core_data, mem_rdata;
  logic              core_stall, mem_req;
  logic [15:0]       miss_cnt;

  int nchk = 0;
  int nfail = 0;
  bit mvalid [LINES];
  int mtag   [LINES];
  int mcnt;

  always #5 clk = ~clk;

  icache_refill #(.INST_W(INST_W), .ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .en(en), .inv(inv), .core_addr(core_addr),
    .core_data(core_data), .core_stall(core_stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .miss_cnt(miss_cnt)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(int a);
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  function automatic int lidx(int a); return (a >> OFF_W) % LINES; endfunction
  function automatic int ltag(int a); return a >> (OFF_W + IDX_W); endfunction
  function automatic bit mhit(int a); return mvalid[lidx(a)] && mtag[lidx(a)] == ltag(a); endfunction

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch at address a. On a miss, serve the refill with gd cycles of gnt delay,
  // gap idle cycles before each beat, and an optional inv pulse on beat inv_at.
  task automatic access(int a, int gd, int gap, int inv_at);
    int base;
    base = a & ~(WORDS - 1);
    core_addr = ADDR_W'(a);
    en = 1'b1;
    @(negedge clk);
    if (mhit(a)) begin
      chk("hit_stall", 32'(core_stall), 0);
      chk("hit_data", core_data, memw(a));
      chk("hit_cnt", 32'(miss_cnt), mcnt);
      step();
      return;
    end
    chk("miss_stall", 32'(core_stall), 1);
    chk("miss_data", core_data, 0);
    chk("miss_cnt_pre", 32'(miss_cnt), mcnt);
    if (mcnt < 65535) mcnt++;
    step();
    for (int i = 0; i <= gd; i++) begin
      mem_gnt = (i == gd);
      core_addr = ADDR_W'($urandom_range(0, 1023));
      @(negedge clk);
      chk("req", 32'(mem_req), 1);
      chk("req_addr", 32'(mem_addr), base);
      chk("req_stall", 32'(core_stall), 1);
      if (i == 0) chk("miss_cnt", 32'(miss_cnt), mcnt);
      step();
    end
    mem_gnt = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        @(negedge clk);
        chk("gap_req", 32'(mem_req), 0);
        chk("gap_stall", 32'(core_stall), 1);
        step();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = memw(base + w);
      inv        = (w == inv_at);
      core_addr  = ADDR_W'($urandom_range(0, 1023));
      @(negedge clk);
      chk("beat_req", 32'(mem_req), 0);
      chk("beat_stall", 32'(core_stall), 1);
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    inv        = 1'b0;
    if (inv_at >= 0) clear_model();
    @(negedge clk);
    chk("done_stall", 32'(core_stall), 1);
    chk("done_req", 32'(mem_req), 0);
    step();
    if (inv_at < 0) begin
      mvalid[lidx(a)] = 1'b1;
      mtag[lidx(a)]   = ltag(a);
    end
  endtask

  // Lookup with en/inv forced; must stall and must not start a refill.
  task automatic probe(int a, bit e, bit iv);
    core_addr = ADDR_W'(a);
    en  = e;
    inv = iv;
    @(negedge clk);
    chk("probe_stall", 32'(core_stall), 1);
    chk("probe_data", core_data, 0);
    step();
    inv = 1'b0;
    en  = 1'b0;
    if (iv) clear_model();
    @(negedge clk);
    chk("probe_noreq", 32'(mem_req), 0);
    chk("probe_cnt", 32'(miss_cnt), mcnt);
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inv = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    core_addr = '0; mem_rdata = '0;
    clear_model();
    mcnt = 0;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_cnt", 32'(miss_cnt), 0);
    chk("rst_stall", 32'(core_stall), 1);
    step();
    rst = 1'b0;

    // cold miss, same-line hits
    access(10'h005, 0, 0, -1);
    access(10'h005, 0, 0, -1);
    access(10'h004, 0, 0, -1);
    access(10'h006, 0, 0, -1);
    access(10'h007, 0, 0, -1);
    // conflict on the same index
    access(10'h024, 0, 0, -1);
    access(10'h024, 0, 0, -1);
    access(10'h004, 0, 0, -1);
    access(10'h005, 0, 0, -1);
    // delayed gnt, gapped beats
    access(10'h1B2, 5, 1, -1);
    access(10'h1B1, 0, 0, -1);
    access(10'h1B3, 0, 0, -1);
    // invalidate during refill, then re-request
    access(10'h040, 1, 0, 2);
    access(10'h040, 0, 0, -1);
    access(10'h041, 0, 0, -1);
    // en low and inv in IDLE on resident and absent lines
    probe(10'h004, 1'b0, 1'b0);
    probe(10'h3F0, 1'b0, 1'b0);
    probe(10'h041, 1'b1, 1'b1);
    access(10'h041, 1, 0, -1);
    access(10'h042, 0, 0, -1);

    // reset during beat 2 of a refill
    core_addr = 10'h088; en = 1'b1;
    @(negedge clk);
    chk("r_miss", 32'(core_stall), 1);
    step();
    mem_gnt = 1'b1;
    @(negedge clk);
    step();
    mem_gnt = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mem_rvalid = 1'b1; mem_rdata = memw(10'h088 + w);
      @(negedge clk);
      step();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
    @(negedge clk);
    chk("r_mid_req", 32'(mem_req), 0);
    chk("r_mid_stall", 32'(core_stall), 1);
    chk("r_mid_cnt", 32'(miss_cnt), 0);
    step();
    rst = 1'b0; en = 1'b0;
    clear_model();
    mcnt = 0;
    @(negedge clk);
    chk("r_stray_req", 32'(mem_req), 0);
    chk("r_stray_stall", 32'(core_stall), 1);
    step();
    mem_rvalid = 1'b0;
    access(10'h088, 0, 0, -1);
    access(10'h08A, 0, 0, -1);

    // random traffic over a few tags
    for (int n = 0; n < 60; n++) begin
      int a;
      a = ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0)
        probe(a, 1'($urandom_range(0, 1)), 1'b1);
      else
        access(a, $urandom_range(0, 4), $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, WORDS - 1) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
